// File: rtl/bus_bridge_pkg.sv
// Shared constants and state encoding for the byte-stream to register-bus bridge.
// Imported by bus_byte_master and its testbench.
package bus_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] STS_ACK = 8'h06;
  localparam logic [7:0] STS_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDH     = 3'd2,
    ST_WDL     = 3'd3,
    ST_BUS_WR  = 3'd4,
    ST_BUS_RD  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_TX      = 3'd7
  } state_t;

  // States in which the frame is still being received and the RX idle timer runs.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_ADDR) || (s == ST_WDH) || (s == ST_WDL);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter: expired pulses on the MAX-th consecutive enabled cycle
// since the last clear, and stays high while enabled and not cleared.
module bus_timeout_ctr #(
  parameter int MAX = 16
) (
  input  logic i_Bus_Clk,
  input  logic i_Bus_Rst_L,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] TERM = W'(MAX - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != TERM)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A clear in the terminal cycle (new RX byte) beats the timeout.
  assign expired = en && !clr && (count_reg == TERM);

endmodule

// File: rtl/bus_byte_master.sv
// Byte-stream bus master: decodes 'W'/'R' frames from the UART receiver into
// single-beat register-bus transactions and queues ACK/NAK/read data for the transmitter.
module bus_byte_master
  import bus_bridge_pkg::*;
#(
  parameter int RX_TIMEOUT = 10000,
  parameter int RD_TIMEOUT = 16
) (
  input  logic        i_Bus_Clk,
  input  logic        i_Bus_Rst_L,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Ready,
  output logic        o_Bus_CS,
  output logic        o_Bus_Wr_Rd_n,
  output logic [7:0]  o_Bus_Addr,
  output logic [15:0] o_Bus_Wr_Data,
  input  logic [15:0] i_Bus_Rd_Data,
  input  logic        i_Bus_Rd_DV,
  output logic        o_Busy
);

  state_t      state_reg, state_next;
  logic        wr_flag_reg, wr_flag_next;
  logic [7:0]  addr_reg, addr_next;
  logic [15:0] wr_data_reg, wr_data_next;
  logic [7:0]  q_reg [3];
  logic [7:0]  q_next [3];
  logic [1:0]  q_cnt_reg, q_cnt_next;
  logic [1:0]  q_idx_reg, q_idx_next;
  logic [7:0]  q_head;

  logic in_frame;
  logic in_rd_wait;
  logic rx_expired;
  logic rd_expired;

  assign in_frame   = is_rx_state(state_reg);
  assign in_rd_wait = (state_reg == ST_RD_WAIT);

  bus_timeout_ctr #(.MAX(RX_TIMEOUT)) u_rx_idle (
    .i_Bus_Clk   (i_Bus_Clk),
    .i_Bus_Rst_L (i_Bus_Rst_L),
    .clr         (i_Rx_DV || !in_frame),
    .en          (in_frame),
    .expired     (rx_expired)
  );

  bus_timeout_ctr #(.MAX(RD_TIMEOUT)) u_rd_wait (
    .i_Bus_Clk   (i_Bus_Clk),
    .i_Bus_Rst_L (i_Bus_Rst_L),
    .clr         (!in_rd_wait),
    .en          (in_rd_wait),
    .expired     (rd_expired)
  );

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_reg   <= ST_IDLE;
      wr_flag_reg <= 1'b0;
      addr_reg    <= '0;
      wr_data_reg <= '0;
      q_cnt_reg   <= '0;
      q_idx_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      wr_flag_reg <= wr_flag_next;
      addr_reg    <= addr_next;
      wr_data_reg <= wr_data_next;
      q_cnt_reg   <= q_cnt_next;
      q_idx_reg   <= q_idx_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_q
      always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
          q_reg[gi] <= '0;
        end else begin
          q_reg[gi] <= q_next[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    wr_flag_next = wr_flag_reg;
    addr_next    = addr_reg;
    wr_data_next = wr_data_reg;
    q_cnt_next   = q_cnt_reg;
    q_idx_next   = q_idx_reg;
    for (int i = 0; i < 3; i++) begin
      q_next[i] = q_reg[i];
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == CMD_WR)) begin
          wr_flag_next = 1'b1;
          state_next   = ST_ADDR;
        end else if (i_Rx_DV && (i_Rx_Byte == CMD_RD)) begin
          wr_flag_next = 1'b0;
          state_next   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_Rx_DV) begin
          addr_next  = i_Rx_Byte;
          state_next = wr_flag_reg ? ST_WDH : ST_BUS_RD;
        end else if (rx_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_WDH: begin
        if (i_Rx_DV) begin
          wr_data_next[15:8] = i_Rx_Byte;
          state_next         = ST_WDL;
        end else if (rx_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_WDL: begin
        if (i_Rx_DV) begin
          wr_data_next[7:0] = i_Rx_Byte;
          state_next        = ST_BUS_WR;
        end else if (rx_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_BUS_WR: begin
        q_next[0]  = STS_ACK;
        q_cnt_next = 2'd1;
        q_idx_next = 2'd0;
        state_next = ST_TX;
      end
      ST_BUS_RD: begin
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (i_Bus_Rd_DV) begin
          q_next[0]  = STS_ACK;
          q_next[1]  = i_Bus_Rd_Data[15:8];
          q_next[2]  = i_Bus_Rd_Data[7:0];
          q_cnt_next = 2'd3;
          q_idx_next = 2'd0;
          state_next = ST_TX;
        end else if (rd_expired) begin
          q_next[0]  = STS_NAK;
          q_cnt_next = 2'd1;
          q_idx_next = 2'd0;
          state_next = ST_TX;
        end
      end
      ST_TX: begin
        if (i_Tx_Ready) begin
          if (q_idx_reg == (q_cnt_reg - 2'd1)) begin
            q_cnt_next = 2'd0;
            q_idx_next = 2'd0;
            state_next = ST_IDLE;
          end else begin
            q_idx_next = q_idx_reg + 2'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    q_head = 8'h00;
    case (q_idx_reg)
      2'd0:    q_head = q_reg[0];
      2'd1:    q_head = q_reg[1];
      2'd2:    q_head = q_reg[2];
      default: q_head = 8'h00;
    endcase
  end

  assign o_Tx_DV       = (state_reg == ST_TX);
  assign o_Tx_Byte     = o_Tx_DV ? q_head : 8'h00;
  assign o_Bus_CS      = (state_reg == ST_BUS_WR) || (state_reg == ST_BUS_RD);
  assign o_Bus_Wr_Rd_n = (state_reg == ST_BUS_WR);
  assign o_Bus_Addr    = addr_reg;
  assign o_Bus_Wr_Data = wr_data_reg;
  assign o_Busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bus_byte_master.sv
// Testbench for bus_byte_master: vector table, cycle-exact corner sequences,
// and randomized frames checked against a frame-level model.
module tb_bus_byte_master;
  import bus_bridge_pkg::*;

  localparam int RX_TO = 64;
  localparam int RD_TO = 16;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b0;
  logic        bus_cs;
  logic        bus_wr_rd_n;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] rd_data = 16'h0000;
  logic        rd_dv = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  bus_byte_master #(.RX_TIMEOUT(RX_TO), .RD_TIMEOUT(RD_TO)) dut (
    .i_Bus_Clk     (clk),
    .i_Bus_Rst_L   (rst_l),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Tx_DV       (tx_dv),
    .o_Tx_Byte     (tx_byte),
    .i_Tx_Ready    (tx_ready),
    .o_Bus_CS      (bus_cs),
    .o_Bus_Wr_Rd_n (bus_wr_rd_n),
    .o_Bus_Addr    (bus_addr),
    .o_Bus_Wr_Data (bus_wr_data),
    .i_Bus_Rd_Data (rd_data),
    .i_Bus_Rd_DV   (rd_dv),
    .o_Busy        (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 1;   // 0 = stall, 1 = always ready, 2 = random
  int tx_first_cyc = -1;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          cyc;
  } cs_ev_t;

  cs_ev_t     cs_q[$];
  logic [7:0] tx_q[$];
  cs_ev_t     exp_cs[$];
  logic [7:0] exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: log bus strobes and TX handshakes, and check the TX byte holds while stalled.
  logic       prev_dv = 1'b0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  always @(negedge clk) begin
    if (rst_l) begin
      if (bus_cs) cs_q.push_back('{bus_wr_rd_n, bus_addr, bus_wr_data, cyc});
      if (tx_dv && !prev_dv) tx_first_cyc = cyc;
      if (tx_dv && prev_dv && !prev_acc) check("tx_hold", {24'h0, tx_byte}, {24'h0, prev_byte});
      if (tx_dv && tx_ready) tx_q.push_back(tx_byte);
    end
    prev_dv   = tx_dv && rst_l;
    prev_acc  = tx_ready;
    prev_byte = tx_byte;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  // Called in the CS cycle; Rd_DV arrives d cycles later.
  task automatic slave_reply(input int d, input logic [15:0] data);
    repeat (d) tick();
    rd_dv   = 1'b1;
    rd_data = data;
    tick();
    rd_dv   = 1'b0;
    rd_data = $urandom_range(0, 65535);
  endtask

  task automatic drive_frame(input logic [31:0] fb, input int n, input int gap,
                             input int delay, input logic [15:0] rdata);
    for (int i = 0; i < n; i++) begin
      send_byte(fb[31-8*i -: 8]);
      if (i < n - 1) idle(gap);
    end
    if (fb[31:24] == CMD_RD && n == 2 && delay > 0) slave_reply(delay, rdata);
    if ((fb[31:24] == CMD_WR && n < 4) || (fb[31:24] == CMD_RD && n < 2)) idle(RX_TO);
  endtask

  // Frame-level reference: what a complete/incomplete frame must produce.
  task automatic expect_frame(input logic [31:0] fb, input int n, input int delay,
                              input logic [15:0] rdata);
    if (fb[31:24] == CMD_WR && n == 4) begin
      exp_cs.push_back('{1'b1, fb[23:16], fb[15:0], 0});
      exp_tx.push_back(STS_ACK);
    end else if (fb[31:24] == CMD_RD && n == 2) begin
      exp_cs.push_back('{1'b0, fb[23:16], 16'h0, 0});
      if (delay >= 1 && delay <= RD_TO) begin
        exp_tx.push_back(STS_ACK);
        exp_tx.push_back(rdata[15:8]);
        exp_tx.push_back(rdata[7:0]);
      end else begin
        exp_tx.push_back(STS_NAK);
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, {31'h0, busy}, 32'h0);
    tick();
  endtask

  task automatic compare_and_clear(input string name);
    int m;
    check({name, "_ncs"}, cs_q.size(), exp_cs.size());
    m = (cs_q.size() < exp_cs.size()) ? cs_q.size() : exp_cs.size();
    for (int i = 0; i < m; i++) begin
      check({name, "_wr"}, {31'h0, cs_q[i].wr}, {31'h0, exp_cs[i].wr});
      check({name, "_addr"}, {24'h0, cs_q[i].addr}, {24'h0, exp_cs[i].addr});
      if (exp_cs[i].wr) check({name, "_wdata"}, {16'h0, cs_q[i].wdata}, {16'h0, exp_cs[i].wdata});
    end
    check({name, "_ntx"}, tx_q.size(), exp_tx.size());
    m = (tx_q.size() < exp_tx.size()) ? tx_q.size() : exp_tx.size();
    for (int i = 0; i < m; i++) check({name, "_txbyte"}, {24'h0, tx_q[i]}, {24'h0, exp_tx[i]});
    cs_q.delete();
    tx_q.delete();
    exp_cs.delete();
    exp_tx.delete();
    tx_first_cyc = -1;
  endtask

  task automatic run_frame(input string name, input logic [31:0] fb, input int n,
                           input int gap, input int delay, input logic [15:0] rdata);
    expect_frame(fb, n, delay, rdata);
    drive_frame(fb, n, gap, delay, rdata);
    wait_idle(name, 400);
    compare_and_clear(name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cs"}, {31'h0, bus_cs}, 32'h0);
    check({name, "_wrn"}, {31'h0, bus_wr_rd_n}, 32'h0);
    check({name, "_addr"}, {24'h0, bus_addr}, 32'h0);
    check({name, "_wdata"}, {16'h0, bus_wr_data}, 32'h0);
    check({name, "_txdv"}, {31'h0, tx_dv}, 32'h0);
    check({name, "_txbyte"}, {24'h0, tx_byte}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] fb;
    int          n;
    int          delay;
    logic [15:0] rdata;
    int          ncs;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          ntx;
    logic [23:0] tx;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_addr;
    int rtype;
    logic [31:0] fb;
    int n;
    int delay;
    logic [15:0] rdata;

    vecs[0] = '{32'h5712ABCD, 4, 0,  16'h0000, 1, 1'b1, 8'h12, 16'hABCD, 1, 24'h060000};
    vecs[1] = '{32'h52120000, 2, 1,  16'hABCD, 1, 1'b0, 8'h12, 16'h0000, 3, 24'h06ABCD};
    vecs[2] = '{32'h52340000, 2, 0,  16'h0000, 1, 1'b0, 8'h34, 16'h0000, 1, 24'h150000};
    vecs[3] = '{32'h41000000, 1, 0,  16'h0000, 0, 1'b0, 8'h00, 16'h0000, 0, 24'h000000};
    vecs[4] = '{32'h52770000, 2, 16, 16'h1234, 1, 1'b0, 8'h77, 16'h0000, 3, 24'h061234};
    vecs[5] = '{32'h52780000, 2, 17, 16'h5555, 1, 1'b0, 8'h78, 16'h0000, 1, 24'h150000};
    vecs[6] = '{32'h57FF0001, 4, 0,  16'h0000, 1, 1'b1, 8'hFF, 16'h0001, 1, 24'h060000};
    vecs[7] = '{32'h52000000, 1, 0,  16'h0000, 0, 1'b0, 8'h00, 16'h0000, 0, 24'h000000};
    vecs[8] = '{32'h57A5FFFF, 4, 0,  16'h0000, 1, 1'b1, 8'hA5, 16'hFFFF, 1, 24'h060000};

    // Reset state
    idle(3);
    check_all_zero("reset");
    rst_l = 1'b1;
    idle(2);

    // Vector table
    ready_mode = 1;
    for (int v = 0; v < 9; v++) begin
      drive_frame(vecs[v].fb, vecs[v].n, 1, vecs[v].delay, vecs[v].rdata);
      if (vecs[v].ncs > 0) exp_cs.push_back('{vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0});
      for (int j = 0; j < vecs[v].ntx; j++) exp_tx.push_back(vecs[v].tx[23-8*j -: 8]);
      wait_idle($sformatf("vec%0d", v), 400);
      compare_and_clear($sformatf("vec%0d", v));
      $display("vec %0d frame=%08h done", v, vecs[v].fb);
    end

    // Write timing: CS at N+1, ACK presented at N+2
    send_byte(CMD_WR); send_byte(8'h12); send_byte(8'hAB);
    n_addr = cyc;
    send_byte(8'hCD);
    wait_idle("wr_t", 50);
    check("wr_t_cscyc", (cs_q.size() > 0) ? cs_q[0].cyc : -1, n_addr + 1);
    check("wr_t_txcyc", tx_first_cyc, n_addr + 2);
    expect_frame(32'h5712ABCD, 4, 0, 16'h0);
    compare_and_clear("wr_t");

    // Read timing: CS at N+1, Rd_DV at N+2, response at N+3
    send_byte(CMD_RD);
    n_addr = cyc;
    send_byte(8'h12);
    slave_reply(1, 16'hABCD);
    wait_idle("rd_t", 50);
    check("rd_t_cscyc", (cs_q.size() > 0) ? cs_q[0].cyc : -1, n_addr + 1);
    check("rd_t_txcyc", tx_first_cyc, n_addr + 3);
    expect_frame(32'h52120000, 2, 1, 16'hABCD);
    compare_and_clear("rd_t");

    // Read timeout: NAK presented at N+2+RD_TIMEOUT
    send_byte(CMD_RD);
    n_addr = cyc;
    send_byte(8'h34);
    wait_idle("rto", 100);
    check("rto_txcyc", tx_first_cyc, n_addr + 2 + RD_TO);
    expect_frame(32'h52340000, 2, 0, 16'h0);
    compare_and_clear("rto");

    // RX abort after exactly RX_TIMEOUT idle cycles, then a normal read
    send_byte(CMD_WR); send_byte(8'h01);
    idle(RX_TO);
    check("abort_busy", {31'h0, busy}, 32'h0);
    send_byte(8'hAB); send_byte(8'hCD);
    idle(4);
    compare_and_clear("abort");
    run_frame("after_abort", 32'h52010000, 2, 0, 3, 16'h0F0F);
    // Gaps of RX_TIMEOUT-1 keep the frame alive
    run_frame("gap_max", 32'h5701BEEF, 4, RX_TO - 1, 0, 16'h0);

    // TX backpressure with dropped RX bytes
    ready_mode = 0;
    idle(1);
    send_byte(CMD_RD);
    send_byte(8'h5A);
    slave_reply(2, 16'hC3E1);
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) send_byte((i % 8 == 0) ? CMD_WR : CMD_RD);
      else tick();
    end
    check("bp_held", {31'h0, tx_dv}, 32'h1);
    ready_mode = 1;
    wait_idle("bp", 50);
    expect_frame(32'h525A0000, 2, 2, 16'hC3E1);
    compare_and_clear("bp");

    // Reset mid-frame
    send_byte(CMD_WR); send_byte(8'h12);
    #2 rst_l = 1'b0;
    #1 check_all_zero("rst_frame");
    tick();
    rst_l = 1'b1;
    tick();
    compare_and_clear("rst_frame_post");
    run_frame("after_rst1", 32'h57345678, 4, 0, 0, 16'h0);

    // Reset mid-TX
    ready_mode = 0;
    idle(1);
    send_byte(CMD_RD); send_byte(8'h12);
    slave_reply(1, 16'h9876);
    idle(3);
    check("rst_tx_pre", {31'h0, tx_dv}, 32'h1);
    #2 rst_l = 1'b0;
    #1 check_all_zero("rst_tx");
    tick();
    rst_l = 1'b1;
    ready_mode = 1;
    tick();
    cs_q.delete();
    compare_and_clear("rst_tx_post");
    run_frame("after_rst2", 32'h52120000, 2, 1, 16'h4321, 16'h4321);

    // Randomized frames against the frame-level model
    ready_mode = 2;
    for (int k = 0; k < 60; k++) begin
      rtype = $urandom_range(0, 9);
      fb    = $urandom;
      delay = 0;
      rdata = $urandom_range(0, 65535);
      if (rtype <= 3) begin
        fb[31:24] = CMD_WR; n = 4;
      end else if (rtype <= 7) begin
        fb[31:24] = CMD_RD; n = 2; delay = $urandom_range(0, 20);
      end else if (rtype == 8) begin
        n = 1;
        while (fb[31:24] == CMD_WR || fb[31:24] == CMD_RD) fb[31:24] = $urandom_range(0, 255);
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          fb[31:24] = CMD_WR; n = $urandom_range(1, 3);
        end else begin
          fb[31:24] = CMD_RD; n = 1;
        end
      end
      run_frame($sformatf("rand%0d", k), fb, n, $urandom_range(0, 4), delay, rdata);
      $display("rand %0d frame=%08h n=%0d delay=%0d", k, fb, n, delay);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
